wb_regfile: RTL and testbench

//  Writeback end of the MEM/WB pipeline interface. Consumes the MEM/WB register outputs and selects
//  the writeback data. Owns the 32x32 general register file, with write-through bypass to the two
//  ID-stage read ports. Also keeps a retired-instruction counter and emits a one-cycle-late write trace.

---
 rtl/wb_regfile_if.sv | 42 ++++
 rtl/wb_regfile.sv | 110 +++++++++++
 tb/tb_wb_regfile.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bundle: pipeline register outputs, ID read ports,
// forwarding taps, retire counter and write trace.
interface wb_regfile_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      wb_ir;
  logic [4:0]       wb_a3;
  logic [31:0]      wb_ao;
  logic [31:0]      wb_dr;
  logic [31:0]      wb_pcp4;
  logic             wb_regwrite;
  logic             wb_memtoreg;
  logic             wb_link;
  logic             wb_away;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic [31:0]      wb_wd;
  logic             wb_we;
  logic [CNT_W-1:0] retire_cnt;
  logic             trace_valid;
  logic [31:0]      trace_pc;
  logic [4:0]       trace_a3;
  logic [31:0]      trace_wd;

  modport master (
    output wb_ir, wb_a3, wb_ao, wb_dr, wb_pcp4,
    output wb_regwrite, wb_memtoreg, wb_link, wb_away,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_wd, wb_we,
    input  retire_cnt, trace_valid, trace_pc, trace_a3, trace_wd
  );

  modport slave (
    input  wb_ir, wb_a3, wb_ao, wb_dr, wb_pcp4,
    input  wb_regwrite, wb_memtoreg, wb_link, wb_away,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_wd, wb_we,
    output retire_cnt, trace_valid, trace_pc, trace_a3, trace_wd
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: write-data select, 32x32 GPR file with same-cycle bypass
// to the ID read ports, retired-instruction counter and one-cycle-late write trace.
module wb_regfile #(
  parameter logic [31:0] PC_BASE = 32'h0000_3000,
  parameter int unsigned CNT_W   = 32
) (
  input logic         CLK,
  input logic         reset,
  wb_regfile_if.slave bus
);

  logic [31:0]      wd_s;
  logic             we_s;
  logic             retire_s;
  logic [31:0]      rs_data_s;
  logic [31:0]      rt_data_s;

  logic [31:0]      gpr_r [0:31];
  logic [CNT_W-1:0] retire_cnt_r;
  logic             trace_valid_r;
  logic [31:0]      trace_pc_r;
  logic [4:0]       trace_a3_r;
  logic [31:0]      trace_wd_r;

  // Write-data select (link beats memtoreg), effective write enable, retire qualifier
  always_comb begin
    wd_s = bus.wb_ao;
    if (bus.wb_link) begin
      wd_s = bus.wb_pcp4 + 32'd4;
    end else if (bus.wb_memtoreg) begin
      wd_s = bus.wb_dr;
    end else begin
      wd_s = bus.wb_ao;
    end
    we_s     = bus.wb_regwrite & ~bus.wb_away & (bus.wb_a3 != 5'd0);
    retire_s = ~bus.wb_away & (bus.wb_ir != 32'd0);
  end

  // Read port 1 with write-through bypass; $0 is hard zero
  always_comb begin
    rs_data_s = 32'd0;
    if (bus.rs_addr == 5'd0) begin
      rs_data_s = 32'd0;
    end else if (we_s && (bus.rs_addr == bus.wb_a3)) begin
      rs_data_s = wd_s;
    end else begin
      rs_data_s = gpr_r[bus.rs_addr];
    end
  end

  // Read port 2 with write-through bypass; $0 is hard zero
  always_comb begin
    rt_data_s = 32'd0;
    if (bus.rt_addr == 5'd0) begin
      rt_data_s = 32'd0;
    end else if (we_s && (bus.rt_addr == bus.wb_a3)) begin
      rt_data_s = wd_s;
    end else begin
      rt_data_s = gpr_r[bus.rt_addr];
    end
  end

  // GPR array; entry 0 is never written because we_s excludes a3==0
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        gpr_r[i] <= 32'd0;
      end
    end else if (we_s) begin
      gpr_r[bus.wb_a3] <= wd_s;
    end
  end

  // Retired-instruction counter: bubbles (ir==0) and annulled instructions excluded
  always_ff @(posedge CLK) begin
    if (reset) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Write trace: valid pulses for every GPR write, fields hold between writes
  always_ff @(posedge CLK) begin
    if (reset) begin
      trace_valid_r <= 1'b0;
      trace_pc_r    <= PC_BASE;
      trace_a3_r    <= 5'd0;
      trace_wd_r    <= 32'd0;
    end else begin
      trace_valid_r <= we_s;
      if (we_s) begin
        trace_pc_r <= bus.wb_pcp4 - 32'd4;
        trace_a3_r <= bus.wb_a3;
        trace_wd_r <= wd_s;
      end
    end
  end

  assign bus.wb_wd       = wd_s;
  assign bus.wb_we       = we_s;
  assign bus.rs_data     = rs_data_s;
  assign bus.rt_data     = rt_data_s;
  assign bus.retire_cnt  = retire_cnt_r;
  assign bus.trace_valid = trace_valid_r;
  assign bus.trace_pc    = trace_pc_r;
  assign bus.trace_a3    = trace_a3_r;
  assign bus.trace_wd    = trace_wd_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed corner cases followed by
// randomized traffic against an architectural register-file model.
module tb_wb_regfile;
  localparam int unsigned CNT_W = 32;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  wb_regfile_if #(.CNT_W(CNT_W)) bus ();

  wb_regfile #(.PC_BASE(32'h0000_3000), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // architectural state as the ISA sees it
  logic [31:0] m_gpr [32];
  logic [31:0] m_cnt;
  logic        m_tv;
  logic [31:0] m_tpc;
  logic [4:0]  m_ta3;
  logic [31:0] m_twd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_cnt = 32'd0;
    m_tv  = 1'b0;
    m_tpc = 32'h0000_3000;
    m_ta3 = 5'd0;
    m_twd = 32'd0;
  endtask

  function automatic logic [31:0] exp_wd();
    if (bus.wb_link) return bus.wb_pcp4 + 32'd4;
    if (bus.wb_memtoreg) return bus.wb_dr;
    return bus.wb_ao;
  endfunction

  function automatic logic exp_we();
    return bus.wb_regwrite && !bus.wb_away && (bus.wb_a3 != 5'd0);
  endfunction

  // what the ID stage must observe this cycle for a register
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exp_we() && a == bus.wb_a3) return exp_wd();
    return m_gpr[a];
  endfunction

  task automatic drive(input logic [31:0] ir, input logic [4:0] a3,
                       input logic [31:0] ao, input logic [31:0] dr, input logic [31:0] pcp4,
                       input logic rw, input logic mtr, input logic lk, input logic aw,
                       input logic [4:0] rs, input logic [4:0] rt, input logic rst);
    bus.wb_ir = ir;       bus.wb_a3 = a3;        bus.wb_ao = ao;
    bus.wb_dr = dr;       bus.wb_pcp4 = pcp4;    bus.wb_regwrite = rw;
    bus.wb_memtoreg = mtr; bus.wb_link = lk;     bus.wb_away = aw;
    bus.rs_addr = rs;     bus.rt_addr = rt;      reset = rst;
  endtask

  // check combinational outputs, clock once, advance model, check registered outputs
  task automatic cycle();
    logic [31:0] wd;
    logic        we;
    #2;
    wd = exp_wd();
    we = exp_we();
    check("wb_wd", bus.wb_wd, wd);
    check("wb_we", {31'd0, bus.wb_we}, {31'd0, we});
    check("rs_data", bus.rs_data, exp_read(bus.rs_addr));
    check("rt_data", bus.rt_data, exp_read(bus.rt_addr));
    @(posedge CLK);
    if (reset) begin
      model_reset();
    end else begin
      if (we) begin
        m_gpr[bus.wb_a3] = wd;
        m_tpc = bus.wb_pcp4 - 32'd4;
        m_ta3 = bus.wb_a3;
        m_twd = wd;
      end
      m_tv = we;
      if (!bus.wb_away && bus.wb_ir != 32'd0) m_cnt = m_cnt + 32'd1;
    end
    #1;
    check("retire_cnt", bus.retire_cnt, m_cnt);
    check("trace_valid", {31'd0, bus.trace_valid}, {31'd0, m_tv});
    check("trace_pc", bus.trace_pc, m_tpc);
    check("trace_a3", {27'd0, bus.trace_a3}, {27'd0, m_ta3});
    check("trace_wd", bus.trace_wd, m_twd);
  endtask

  initial begin
    model_reset();
    drive(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
    @(posedge CLK);
    #1;
    cycle();  // second reset cycle, now with a defined array

    // all registers read zero after reset
    for (int a = 0; a < 32; a++) begin
      drive(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'(a), 5'(31 - a), 1'b0);
      cycle();
    end

    // ALU write with same-cycle bypass, then read from the array
    drive(32'h0000_0021, 5'd5, 32'h1234, 32'd0, 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 1'b0);
    cycle();
    drive(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0);
    cycle();

    // link has priority over memtoreg
    drive(32'h0C00_0000, 5'd31, 32'h1111, 32'h2222, 32'h3008, 1'b1, 1'b1, 1'b1, 1'b0, 5'd31, 5'd5, 1'b0);
    cycle();
    drive(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 5'd31, 1'b0);
    cycle();

    // write to $0: no write, no trace, still retires
    drive(32'h2000_FFFF, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h300C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    cycle();

    // annulled load: nothing happens
    drive(32'h8C07_0000, 5'd7, 32'd0, 32'hABCD, 32'h3010, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 1'b0);
    cycle();
    drive(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 1'b0);
    cycle();

    // reset drops a write presented in the same cycle
    drive(32'h0000_0001, 5'd9, 32'h55, 32'd0, 32'h3014, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 1'b0);
    cycle();
    drive(32'h0000_0001, 5'd9, 32'h77, 32'd0, 32'h3018, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 1'b1);
    cycle();
    drive(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 1'b0);
    cycle();

    // link data wraps past 2^32
    drive(32'h0C00_0001, 5'd3, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd3, 1'b0);
    cycle();
    drive(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b0);
    cycle();

    // randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      logic [4:0]  a3;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] ir;
      a3 = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
      ir = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      drive(ir, a3, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
            rs, rt, 1'($urandom_range(0, 49) == 0));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
